// File: rtl/i2c_target_regs_if.sv
// Pin and register-bus bundle for the I2C register target.
// The slave modport is the target's view; master is the board/bench side.
interface i2c_target_regs_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  scl_in;
  logic                  sda_in;
  logic                  sda_enable;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [7:0]            reg_wdata;
  logic                  reg_we;
  logic                  reg_re;
  logic [7:0]            reg_rdata;
  logic                  active;

  modport slave (
    input  scl_in, sda_in, reg_rdata,
    output sda_enable, reg_addr, reg_wdata, reg_we, reg_re, active
  );

  modport master (
    output scl_in, sda_in, reg_rdata,
    input  sda_enable, reg_addr, reg_wdata, reg_we, reg_re, active
  );
endinterface

// File: rtl/i2c_target_regs.sv
// EEPROM-style I2C target: first written byte sets a register pointer, then
// data bytes are written or read through it with auto-increment.
module i2c_target_regs #(
  parameter logic [6:0] DEVICE_ADDR = 7'h42,
  parameter int         ADDR_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  i2c_target_regs_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK_WAIT, IGNORE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  // Two-flop synchronisers plus a previous-value stage for edge detection.
  logic scl_m_q, scl_s_q, scl_p_q;
  logic sda_m_q, sda_s_q, sda_p_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_m_q <= 1'b1;
      scl_s_q <= 1'b1;
      scl_p_q <= 1'b1;
      sda_m_q <= 1'b1;
      sda_s_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_m_q <= bus.scl_in;
      scl_s_q <= scl_m_q;
      scl_p_q <= scl_s_q;
      sda_m_q <= bus.sda_in;
      sda_s_q <= sda_m_q;
      sda_p_q <= sda_s_q;
    end
  end

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  assign scl_rise  = scl_s_q & ~scl_p_q;
  assign scl_fall  = ~scl_s_q & scl_p_q;
  assign start_det = scl_s_q & scl_p_q & sda_p_q & ~sda_s_q;
  assign stop_det  = scl_s_q & scl_p_q & ~sda_p_q & sda_s_q;

  state_e                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  sda_en_q, sda_en_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  active_q, active_d;
  logic                  load_q;
  logic                  acked_q, acked_d;

  assign rx_byte = {shift_q[6:0], sda_s_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rw_q      <= 1'b0;
      ptr_q     <= '0;
      sda_en_q  <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      wdata_q   <= '0;
      active_q  <= 1'b0;
      load_q    <= 1'b0;
      acked_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      sda_en_q  <= sda_en_d;
      we_q      <= we_d;
      re_q      <= re_d;
      wdata_q   <= wdata_d;
      active_q  <= active_d;
      load_q    <= re_q;
      acked_q   <= acked_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    sda_en_d  = sda_en_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    wdata_d   = wdata_q;
    active_d  = active_q;
    acked_d   = acked_q;

    if (we_q) ptr_d = ptr_q + PTR_ONE;
    if (load_q) shift_d = bus.reg_rdata;

    // Bus conditions override any bit in flight; a partial byte is dropped.
    if (stop_det) begin
      state_d  = IDLE;
      sda_en_d = 1'b0;
      active_d = 1'b0;
      acked_d  = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_en_d  = 1'b0;
      active_d  = 1'b0;
      acked_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ADDR) begin
                if (rx_byte[7:1] == DEVICE_ADDR) begin
                  state_d  = ADDR_ACK;
                  rw_d     = rx_byte[0];
                  re_d     = rx_byte[0];
                  active_d = 1'b1;
                end else begin
                  state_d = IGNORE;
                end
              end else if (state_q == PTR) begin
                ptr_d   = ADDR_WIDTH'(rx_byte);
                state_d = PTR_ACK;
              end else begin
                we_d    = 1'b1;
                wdata_d = rx_byte;
                state_d = WDATA_ACK;
              end
            end
          end
        end

        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_en_q) begin
              sda_en_d = 1'b1;
            end else begin
              sda_en_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ADDR_ACK && rw_q) begin
                state_d   = RDATA;
                sda_en_d  = ~shift_q[7];
                shift_d   = {shift_q[6:0], 1'b0};
                bit_cnt_d = 3'd1;
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end

        // bit_cnt counts driven bits; it wraps to 0 once all eight are out.
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_en_d = 1'b0;
              state_d  = RACK_WAIT;
            end else begin
              sda_en_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end

        RACK_WAIT: begin
          if (scl_rise && !acked_q) begin
            if (!sda_s_q) begin
              acked_d = 1'b1;
              ptr_d   = ptr_q + PTR_ONE;
              re_d    = 1'b1;
            end else begin
              state_d  = IGNORE;
              active_d = 1'b0;
            end
          end else if (scl_fall && acked_q) begin
            acked_d   = 1'b0;
            state_d   = RDATA;
            sda_en_d  = ~shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = 3'd1;
          end
        end

        default: ;
      endcase
    end
  end

  assign bus.sda_enable = sda_en_q;
  assign bus.reg_addr   = ptr_q;
  assign bus.reg_wdata  = wdata_q;
  assign bus.reg_we     = we_q;
  assign bus.reg_re     = re_q;
  assign bus.active     = active_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged I2C controller on an
// open-drain SDA line plus a register model returning addr ^ 0x5A.
module tb_i2c_target_regs;
  localparam int Q = 20;  // quarter SCL period in clk cycles

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic scl_drv = 1'b1;
  logic sda_low = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  i2c_target_regs_if #(.ADDR_WIDTH(8)) bus ();

  assign bus.scl_in    = scl_drv;
  assign bus.sda_in    = ~(sda_low | bus.sda_enable);
  assign bus.reg_rdata = bus.reg_addr ^ 8'h5A;

  i2c_target_regs #(.DEVICE_ADDR(7'h42), .ADDR_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Strobe monitor, sampled on the falling clk edge.
  logic [15:0] we_log[$];
  logic [7:0]  re_log[$];
  int          overlap_cnt = 0;
  int          sda_cnt = 0;
  int          act_cnt = 0;

  always @(negedge clk) begin
    if (bus.reg_we) we_log.push_back({bus.reg_addr, bus.reg_wdata});
    if (bus.reg_re) re_log.push_back(bus.reg_addr);
    if (bus.reg_we && bus.reg_re) overlap_cnt++;
    if (bus.sda_enable) sda_cnt++;
    if (bus.active) act_cnt++;
  end

  function automatic logic [15:0] we_at(int i);
    return (i < we_log.size()) ? we_log[i] : 16'hxxxx;
  endfunction

  function automatic logic [7:0] re_at(int i);
    return (i < re_log.size()) ? re_log[i] : 8'hxx;
  endfunction

  task automatic wait_q(int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_low = 1'b0; scl_drv = 1'b1; wait_q();
    sda_low = 1'b1; wait_q();
    scl_drv = 1'b0; wait_q();
  endtask

  task automatic i2c_rstart;
    sda_low = 1'b0; wait_q();
    scl_drv = 1'b1; wait_q();
    sda_low = 1'b1; wait_q();
    scl_drv = 1'b0; wait_q();
  endtask

  task automatic i2c_stop;
    sda_low = 1'b1; wait_q();
    scl_drv = 1'b1; wait_q();
    sda_low = 1'b0; wait_q();
  endtask

  task automatic put_bit(input logic b);
    sda_low = ~b; wait_q();
    scl_drv = 1'b1; wait_q(2);
    scl_drv = 1'b0; wait_q();
  endtask

  task automatic get_bit(output logic b);
    sda_low = 1'b0; wait_q();
    scl_drv = 1'b1; wait_q();
    b = bus.sda_in; wait_q();
    scl_drv = 1'b0; wait_q();
  endtask

  task automatic put_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic get_byte(output logic [7:0] v, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(~ack);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; scl_drv = 1'b1; sda_low = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (bus.sda_enable !== 1'b0) begin bad++; $display("FAIL reset_sda_enable: got %b want 0", bus.sda_enable); end
    total++; if (bus.reg_we !== 1'b0) begin bad++; $display("FAIL reset_reg_we: got %b want 0", bus.reg_we); end
    total++; if (bus.reg_re !== 1'b0) begin bad++; $display("FAIL reset_reg_re: got %b want 0", bus.reg_re); end
    total++; if (bus.active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", bus.active); end
    total++; if (bus.reg_addr !== 8'h00) begin bad++; $display("FAIL reset_reg_addr: got %h want 00", bus.reg_addr); end
    total++; if (bus.reg_wdata !== 8'h00) begin bad++; $display("FAIL reset_reg_wdata: got %h want 00", bus.reg_wdata); end
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (bus.sda_enable !== 1'b0) begin bad++; $display("FAIL post_reset_sda: got %b want 0", bus.sda_enable); end
  endtask

  task automatic test_write;
    int wb = we_log.size();
    int rb = re_log.size();
    logic [3:0] ack;
    i2c_start;
    put_byte(8'h84, ack[3]);
    put_byte(8'h10, ack[2]);
    put_byte(8'hA5, ack[1]);
    put_byte(8'h3C, ack[0]);
    total++; if (ack !== 4'b1111) begin bad++; $display("FAIL write_acks: got %b want 1111", ack); end
    total++; if (bus.active !== 1'b1) begin bad++; $display("FAIL write_active: got %b want 1", bus.active); end
    i2c_stop;
    total++; if (we_log.size() - wb !== 2) begin bad++; $display("FAIL write_we_count: got %0d want 2", we_log.size() - wb); end
    total++; if (we_at(wb) !== 16'h10A5) begin bad++; $display("FAIL write_we0: got %h want 10a5", we_at(wb)); end
    total++; if (we_at(wb + 1) !== 16'h113C) begin bad++; $display("FAIL write_we1: got %h want 113c", we_at(wb + 1)); end
    total++; if (bus.reg_addr !== 8'h12) begin bad++; $display("FAIL write_final_ptr: got %h want 12", bus.reg_addr); end
    total++; if (bus.active !== 1'b0) begin bad++; $display("FAIL write_active_after_stop: got %b want 0", bus.active); end
    total++; if (re_log.size() - rb !== 0) begin bad++; $display("FAIL write_no_re: got %0d want 0", re_log.size() - rb); end
  endtask

  task automatic test_random_read;
    int wb = we_log.size();
    int rb = re_log.size();
    logic [2:0] ack;
    logic [7:0] d0, d1;
    i2c_start;
    put_byte(8'h84, ack[2]);
    put_byte(8'h20, ack[1]);
    i2c_rstart;
    put_byte(8'h85, ack[0]);
    get_byte(d0, 1'b1);
    get_byte(d1, 1'b0);
    i2c_stop;
    total++; if (ack !== 3'b111) begin bad++; $display("FAIL read_acks: got %b want 111", ack); end
    total++; if (d0 !== 8'h7A) begin bad++; $display("FAIL read_byte0: got %h want 7a", d0); end
    total++; if (d1 !== 8'h7B) begin bad++; $display("FAIL read_byte1: got %h want 7b", d1); end
    total++; if (re_at(rb) !== 8'h20) begin bad++; $display("FAIL read_re0: got %h want 20", re_at(rb)); end
    total++; if (re_at(rb + 1) !== 8'h21) begin bad++; $display("FAIL read_re1: got %h want 21", re_at(rb + 1)); end
    total++; if (re_log.size() - rb < 2 || re_log.size() - rb > 3) begin bad++; $display("FAIL read_re_count: got %0d want 2..3", re_log.size() - rb); end
    total++; if (we_log.size() - wb !== 0) begin bad++; $display("FAIL read_no_we: got %0d want 0", we_log.size() - wb); end
    total++; if (bus.active !== 1'b0) begin bad++; $display("FAIL read_active_after: got %b want 0", bus.active); end
  endtask

  task automatic test_wrong_addr;
    int wb = we_log.size();
    int rb = re_log.size();
    int sb = sda_cnt;
    int ab = act_cnt;
    logic [3:0] ack;
    i2c_start;
    put_byte(8'h86, ack[3]);
    put_byte(8'h11, ack[2]);
    put_byte(8'h22, ack[1]);
    put_byte(8'h33, ack[0]);
    i2c_stop;
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL wrong_addr_acks: got %b want 0000", ack); end
    total++; if (sda_cnt - sb !== 0) begin bad++; $display("FAIL wrong_addr_sda: got %0d cycles want 0", sda_cnt - sb); end
    total++; if (act_cnt - ab !== 0) begin bad++; $display("FAIL wrong_addr_active: got %0d cycles want 0", act_cnt - ab); end
    total++; if ((we_log.size() - wb) + (re_log.size() - rb) !== 0) begin bad++; $display("FAIL wrong_addr_strobes: got %0d want 0", (we_log.size() - wb) + (re_log.size() - rb)); end
  endtask

  task automatic test_wrap;
    int wb = we_log.size();
    logic [3:0] ack;
    i2c_start;
    put_byte(8'h84, ack[3]);
    put_byte(8'hFF, ack[2]);
    put_byte(8'h11, ack[1]);
    put_byte(8'h22, ack[0]);
    i2c_stop;
    total++; if (ack !== 4'b1111) begin bad++; $display("FAIL wrap_acks: got %b want 1111", ack); end
    total++; if (we_at(wb) !== 16'hFF11) begin bad++; $display("FAIL wrap_we0: got %h want ff11", we_at(wb)); end
    total++; if (we_at(wb + 1) !== 16'h0022) begin bad++; $display("FAIL wrap_we1: got %h want 0022", we_at(wb + 1)); end
    total++; if (bus.reg_addr !== 8'h01) begin bad++; $display("FAIL wrap_final_ptr: got %h want 01", bus.reg_addr); end
  endtask

  task automatic test_reset_mid;
    int wb = we_log.size();
    logic [2:0] ack;
    logic [3:0] ack2;
    logic [2:0] bits;
    logic b;
    i2c_start;
    put_byte(8'h84, ack[2]);
    put_byte(8'h30, ack[1]);
    i2c_rstart;
    put_byte(8'h85, ack[0]);
    for (int i = 2; i >= 0; i--) begin
      get_bit(b);
      bits[i] = b;
    end
    total++; if (ack !== 3'b111) begin bad++; $display("FAIL rstmid_acks: got %b want 111", ack); end
    total++; if (bits !== 3'b011) begin bad++; $display("FAIL rstmid_first_bits: got %b want 011", bits); end
    // Fourth bit of 0x6A is 0, so the target should be pulling SDA low.
    sda_low = 1'b0; wait_q();
    scl_drv = 1'b1; wait_q();
    total++; if (bus.sda_enable !== 1'b1) begin bad++; $display("FAIL rstmid_driving: got %b want 1", bus.sda_enable); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (bus.sda_enable !== 1'b0) begin bad++; $display("FAIL rstmid_async_release: got %b want 0", bus.sda_enable); end
    repeat (10) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (we_log.size() - wb !== 0) begin bad++; $display("FAIL rstmid_no_we: got %0d want 0", we_log.size() - wb); end
    total++; if (bus.reg_addr !== 8'h00) begin bad++; $display("FAIL rstmid_ptr_cleared: got %h want 00", bus.reg_addr); end
    i2c_start;
    put_byte(8'h84, ack2[3]);
    put_byte(8'h40, ack2[2]);
    put_byte(8'h55, ack2[1]);
    i2c_stop;
    ack2[0] = 1'b1;
    total++; if (ack2 !== 4'b1111) begin bad++; $display("FAIL rstmid_recover_acks: got %b want 1111", ack2); end
    total++; if (we_at(wb) !== 16'h4055) begin bad++; $display("FAIL rstmid_recover_we: got %h want 4055", we_at(wb)); end
  endtask

  task automatic test_stop_mid;
    int wb = we_log.size();
    logic [1:0] ack;
    logic a;
    i2c_start;
    put_byte(8'h84, ack[1]);
    put_byte(8'h50, ack[0]);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    i2c_stop;
    total++; if (ack !== 2'b11) begin bad++; $display("FAIL stopmid_acks: got %b want 11", ack); end
    total++; if (we_log.size() - wb !== 0) begin bad++; $display("FAIL stopmid_no_we: got %0d want 0", we_log.size() - wb); end
    total++; if (bus.sda_enable !== 1'b0) begin bad++; $display("FAIL stopmid_sda: got %b want 0", bus.sda_enable); end
    total++; if (bus.active !== 1'b0) begin bad++; $display("FAIL stopmid_active: got %b want 0", bus.active); end
    // An idle target must ignore a byte that arrives without a START.
    scl_drv = 1'b0; wait_q();
    put_byte(8'h84, a);
    i2c_stop;
    total++; if (a !== 1'b0) begin bad++; $display("FAIL stopmid_idle_ignores: got ack %b want 0", a); end
    total++; if (bus.reg_addr !== 8'h50) begin bad++; $display("FAIL stopmid_ptr: got %h want 50", bus.reg_addr); end
  endtask

  task automatic test_strobe_exclusive;
    total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL we_re_overlap: got %0d cycles want 0", overlap_cnt); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_random_read();
    test_wrong_addr();
    test_wrap();
    test_reset_mid();
    test_stop_mid();
    test_strobe_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
